// File: rtl/audio_meas_pkg.sv
// Shared FSM state encoding and width helpers for the audio tone meter.
package audio_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Width of a sample index within a window of win samples.
    function automatic int unsigned idx_w(input int unsigned win);
        return $clog2(win);
    endfunction

    // Width of a crossing counter that saturates at max_cross.
    function automatic int unsigned cnt_w(input int unsigned max_cross);
        return $clog2(max_cross + 1);
    endfunction

endpackage

// File: rtl/tone_meter_ch.sv
// Per-channel tone measurement: reference sign/polarity, peaks, crossing indices and count.
// Build option TONE_HYST_EN: crossings need to leave a +/-HYST band around zero.
module tone_meter_ch
    import audio_meas_pkg::*;
#(
    parameter int unsigned SMPL_W    = 16,
    parameter int unsigned IW        = 8,
    parameter int unsigned CW        = 4,
    parameter int unsigned MAX_CROSS = 8
`ifdef TONE_HYST_EN
    ,
    parameter int          HYST      = 64
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     arm_i,
    input  logic                     meas_i,
    input  logic [IW-1:0]            idx_i,
    input  logic signed [SMPL_W-1:0] smpl_i,
    output logic [SMPL_W-1:0]        pk_max_o,
    output logic [SMPL_W-1:0]        pk_min_o,
    output logic [IW-1:0]            first_idx_o,
    output logic [IW-1:0]            last_idx_o,
    output logic [CW-1:0]            cross_cnt_o,
    output logic                     no_tone_o
);

    localparam logic signed [SMPL_W-1:0] SMPL_MIN = {1'b1, {(SMPL_W-1){1'b0}}};
    localparam logic signed [SMPL_W-1:0] SMPL_MAX = {1'b0, {(SMPL_W-1){1'b1}}};
`ifdef TONE_HYST_EN
    localparam logic signed [SMPL_W-1:0] HYST_P   = SMPL_W'(HYST);
    localparam logic signed [SMPL_W-1:0] HYST_N   = SMPL_W'(-HYST);
`endif

    // ref_neg: previous sample sign (plain build) or tracked polarity (hysteresis build)
    logic                     ref_neg_q, ref_neg_d;
    logic signed [SMPL_W-1:0] pk_max_q, pk_max_d;
    logic signed [SMPL_W-1:0] pk_min_q, pk_min_d;
    logic [IW-1:0]            first_q, first_d;
    logic [IW-1:0]            last_q, last_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     no_tone_q, no_tone_d;
    logic                     cross_c;

    // Crossing detect against the reference sign or the hysteresis band
    always_comb begin
`ifdef TONE_HYST_EN
        cross_c = ref_neg_q ? (smpl_i >= HYST_P) : (smpl_i <= HYST_N);
`else
        cross_c = (smpl_i[SMPL_W-1] != ref_neg_q);
`endif
    end

    // Next-state: clear on arm entry, seed on the ARM sample, accumulate during MEAS
    always_comb begin
        ref_neg_d = ref_neg_q;
        pk_max_d  = pk_max_q;
        pk_min_d  = pk_min_q;
        first_d   = first_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        no_tone_d = no_tone_q;
        if (clr_i) begin
            ref_neg_d = 1'b0;
            pk_max_d  = '0;
            pk_min_d  = '0;
            first_d   = '0;
            last_d    = '0;
            cnt_d     = '0;
            no_tone_d = 1'b0;
        end else if (arm_i) begin
            ref_neg_d = smpl_i[SMPL_W-1];
            pk_max_d  = SMPL_MIN;
            pk_min_d  = SMPL_MAX;
        end else if (meas_i) begin
`ifdef TONE_HYST_EN
            if (cross_c) ref_neg_d = ~ref_neg_q;
`else
            ref_neg_d = smpl_i[SMPL_W-1];
`endif
            if (cross_c && (cnt_q != CW'(MAX_CROSS))) begin
                cnt_d  = cnt_q + CW'(1);
                last_d = idx_i;
                if (cnt_q == '0) first_d = idx_i;
            end
            if (smpl_i > pk_max_q) pk_max_d = smpl_i;
            if (smpl_i < pk_min_q) pk_min_d = smpl_i;
            no_tone_d = (cnt_d < CW'(2));
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_neg_q <= 1'b0;
            pk_max_q  <= '0;
            pk_min_q  <= '0;
            first_q   <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            no_tone_q <= 1'b0;
        end else begin
            ref_neg_q <= ref_neg_d;
            pk_max_q  <= pk_max_d;
            pk_min_q  <= pk_min_d;
            first_q   <= first_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            no_tone_q <= no_tone_d;
        end
    end

    assign pk_max_o    = pk_max_q;
    assign pk_min_o    = pk_min_q;
    assign first_idx_o = first_q;
    assign last_idx_o  = last_q;
    assign cross_cnt_o = cnt_q;
    assign no_tone_o   = no_tone_q;

endmodule

// File: rtl/audio_tone_meter.sv
// Multi-channel tone meter: window FSM and shared sample index driving NUM_CH channel meters.
// Build option TONE_HYST_EN enables hysteresis crossing detection in every channel.
module audio_tone_meter
    import audio_meas_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned SMPL_W    = 16,
    parameter int unsigned WIN_SMPLS = 140,
    parameter int unsigned MAX_CROSS = 8,
    parameter int          HYST      = 64,
    localparam int unsigned IW       = idx_w(WIN_SMPLS),
    localparam int unsigned CW       = cnt_w(MAX_CROSS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     smpl_vld,
    input  logic [NUM_CH*SMPL_W-1:0] smpl_in,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH*SMPL_W-1:0] pk_max,
    output logic [NUM_CH*SMPL_W-1:0] pk_min,
    output logic [NUM_CH*IW-1:0]     first_idx,
    output logic [NUM_CH*IW-1:0]     last_idx,
    output logic [NUM_CH*CW-1:0]     cross_cnt,
    output logic [NUM_CH-1:0]        no_tone
);

    // Reject configurations the window logic cannot represent
    if (WIN_SMPLS < 2 || MAX_CROSS < 2 || HYST < 0) begin : g_bad_cfg
        $error("audio_tone_meter: WIN_SMPLS and MAX_CROSS must be >= 2, HYST >= 0");
    end

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic          busy_q;
    logic          done_q;
    logic          clr_c;
    logic          arm_c;
    logic          meas_c;

    // Window strobes shared by all channels
    assign clr_c  = (state_q == ST_IDLE) && start;
    assign arm_c  = (state_q == ST_ARM)  && smpl_vld;
    assign meas_c = (state_q == ST_MEAS) && smpl_vld;

    // Window FSM with sample index counter and registered busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (smpl_vld) begin
                        state_q <= ST_MEAS;
                        idx_q   <= '0;
                    end
                end
                ST_MEAS: begin
                    if (smpl_vld) begin
                        idx_q <= idx_q + IW'(1);
                        if (idx_q == IW'(WIN_SMPLS - 1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tone_meter_ch #(
            .SMPL_W    (SMPL_W),
            .IW        (IW),
            .CW        (CW),
            .MAX_CROSS (MAX_CROSS)
`ifdef TONE_HYST_EN
            ,
            .HYST      (HYST)
`endif
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (clr_c),
            .arm_i       (arm_c),
            .meas_i      (meas_c),
            .idx_i       (idx_q),
            .smpl_i      (smpl_in[c*SMPL_W +: SMPL_W]),
            .pk_max_o    (pk_max[c*SMPL_W +: SMPL_W]),
            .pk_min_o    (pk_min[c*SMPL_W +: SMPL_W]),
            .first_idx_o (first_idx[c*IW +: IW]),
            .last_idx_o  (last_idx[c*IW +: IW]),
            .cross_cnt_o (cross_cnt[c*CW +: CW]),
            .no_tone_o   (no_tone[c])
        );
    end

endmodule

// File: tb/tb_audio_tone_meter.sv
// Scoreboard bench for audio_tone_meter: driver pushes expected window results, monitor checks on done.
module tb_audio_tone_meter;

    localparam int W   = 16;
    localparam int N   = 2;
    localparam int IW  = 8;
    localparam int CW  = 4;
    localparam int WIN = 140;
    localparam logic [N*W-1:0] JUNK = 32'hEC78_EC78;  // -5000 on both channels

    typedef struct {
        logic [15:0] mx;
        logic [15:0] mn;
        logic [7:0]  fi;
        logic [7:0]  la;
        logic [3:0]  cnt;
        logic        nt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            smpl_vld;
    logic [N*W-1:0]  smpl_in;
    logic            busy;
    logic            done;
    logic [N*W-1:0]  pk_max;
    logic [N*W-1:0]  pk_min;
    logic [N*IW-1:0] first_idx;
    logic [N*IW-1:0] last_idx;
    logic [N*CW-1:0] cross_cnt;
    logic [N-1:0]    no_tone;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    audio_tone_meter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .smpl_vld  (smpl_vld),
        .smpl_in   (smpl_in),
        .busy      (busy),
        .done      (done),
        .pk_max    (pk_max),
        .pk_min    (pk_min),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .cross_cnt (cross_cnt),
        .no_tone   (no_tone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Square wave: prev and x=0..8 positive, sign alternates every 10 samples
    function automatic logic [15:0] sq(input int x);
        if (x < 0) return 16'd3200;
        return ((((x + 1) / 10) % 2) == 1) ? 16'hF380 : 16'd3200;
    endfunction

    // Small noise alternating around zero: prev +20, even x negative
    function automatic logic [15:0] alt(input int x);
        if (x < 0) return 16'd20;
        return ((x % 2) == 0) ? 16'hFFEC : 16'd20;
    endfunction

    function automatic logic [15:0] pat(input int p, input int ch, input int x);
        case (p)
            0:       return sq(x);
            1:       return (ch == 0) ? sq(x) : 16'd100;
            default: return alt(x);
        endcase
    endfunction

    // Hand-computed window results
    function automatic exp_t exp_of(input int p, input int ch);
        exp_t e;
        if (p == 0 || (p == 1 && ch == 0)) begin
            e = '{mx: 16'd3200, mn: 16'hF380, fi: 8'd9, la: 8'd79, cnt: 4'd8, nt: 1'b0};
        end else if (p == 1) begin
            e = '{mx: 16'd100, mn: 16'd100, fi: 8'd0, la: 8'd0, cnt: 4'd0, nt: 1'b1};
        end else begin
`ifdef TONE_HYST_EN
            e = '{mx: 16'd20, mn: 16'hFFEC, fi: 8'd0, la: 8'd0, cnt: 4'd0, nt: 1'b1};
`else
            e = '{mx: 16'd20, mn: 16'hFFEC, fi: 8'd0, la: 8'd7, cnt: 4'd8, nt: 1'b0};
`endif
        end
        return e;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_pkmax"}, 32'(pk_max), 32'd0);
        chk({tag, "_pkmin"}, 32'(pk_min), 32'd0);
        chk({tag, "_first"}, 32'(first_idx), 32'd0);
        chk({tag, "_last"},  32'(last_idx), 32'd0);
        chk({tag, "_cnt"},   32'(cross_cnt), 32'd0);
        chk({tag, "_notone"}, 32'(no_tone), 32'd0);
    endtask

    // Monitor: every done pulse pops one expected entry per channel
    always @(negedge clk) begin
        if (done) begin
            for (int ch = 0; ch < N; ch++) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done ch%0d: got done, required no done", ch);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("pk_max_ch%0d", ch),    32'(pk_max[ch*W +: W]),     32'(e.mx));
                    chk($sformatf("pk_min_ch%0d", ch),    32'(pk_min[ch*W +: W]),     32'(e.mn));
                    chk($sformatf("first_idx_ch%0d", ch), 32'(first_idx[ch*IW +: IW]), 32'(e.fi));
                    chk($sformatf("last_idx_ch%0d", ch),  32'(last_idx[ch*IW +: IW]),  32'(e.la));
                    chk($sformatf("cross_cnt_ch%0d", ch), 32'(cross_cnt[ch*CW +: CW]), 32'(e.cnt));
                    chk($sformatf("no_tone_ch%0d", ch),   32'(no_tone[ch]),           32'(e.nt));
                end
            end
        end
    end

    // Drive one window; optional gaps, ignored restart, reset abort, start with smpl_vld
    task automatic run_window(input int p, input int gap, input int restart_x,
                              input int abort_x, input bit vld_on_start, input bit push);
        if (push) begin
            sb_q.push_back(exp_of(p, 0));
            sb_q.push_back(exp_of(p, 1));
        end
        @(negedge clk);
        start    = 1'b1;
        smpl_vld = vld_on_start;
        smpl_in  = JUNK;
        @(negedge clk);
        chk("busy_armed", 32'(busy), 32'd1);
        start    = 1'b0;
        smpl_vld = 1'b1;
        smpl_in  = {pat(p, 1, -1), pat(p, 0, -1)};
        @(negedge clk);
        smpl_vld = 1'b0;
        smpl_in  = JUNK;
        repeat (gap) @(negedge clk);
        for (int x = 0; x < WIN; x++) begin
            if (x == abort_x) begin
                rst      = 1'b1;
                smpl_vld = 1'b0;
                @(negedge clk);
                chk_zero("abort_in_rst");
                rst = 1'b0;
                repeat (3) @(negedge clk);
                chk_zero("abort_after");
                return;
            end
            smpl_vld = 1'b1;
            smpl_in  = {pat(p, 1, x), pat(p, 0, x)};
            start    = (x == restart_x);
            if (x == WIN - 1) begin
                @(posedge clk);
                #1;
                chk("done_latency", 32'(done), 32'd1);
                chk("busy_released", 32'(busy), 32'd0);
                @(negedge clk);
                smpl_vld = 1'b0;
                start    = 1'b0;
                smpl_in  = JUNK;
            end else begin
                @(negedge clk);
                smpl_vld = 1'b0;
                start    = 1'b0;
                smpl_in  = JUNK;
                repeat (gap) @(negedge clk);
            end
        end
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        smpl_vld = 1'b0;
        smpl_in  = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // smpl_vld in IDLE must not arm or disturb anything
        repeat (3) begin
            @(negedge clk);
            smpl_vld = 1'b1;
            smpl_in  = JUNK;
        end
        @(negedge clk);
        smpl_vld = 1'b0;
        @(negedge clk);
        chk("idle_vld_busy", 32'(busy), 32'd0);
        chk("idle_vld_cnt", 32'(cross_cnt), 32'd0);

        run_window(0, 0, -1, -1, 1'b0, 1'b1);  // square wave on both channels
        run_window(1, 0, -1, -1, 1'b0, 1'b1);  // ch0 square, ch1 constant
        run_window(2, 0, -1, -1, 1'b0, 1'b1);  // small alternating noise
        run_window(0, 0, 50, -1, 1'b0, 1'b1);  // start mid-window ignored
        run_window(0, 0, -1, 70, 1'b0, 1'b0);  // reset aborts at x=70
        run_window(0, 0, -1, -1, 1'b0, 1'b1);  // fresh window after abort
        run_window(0, 3, -1, -1, 1'b1, 1'b1);  // gapped samples, start with smpl_vld

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
